// File: rtl/trigger_sequencer_pkg.sv
// trigger_sequencer_pkg: FSM state encodings and default geometry for the trigger sequencer
package trigger_sequencer_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam int NUM_PULSES  = 8;
  localparam int NUM_WIDTH   = 4;
  localparam int DELAY_WIDTH = 24;
  localparam int INDEX_WIDTH = 3;
endpackage

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: match/config inputs and trigger/status outputs of the sequencer
interface trigger_sequencer_if
  import trigger_sequencer_pkg::*;
#(
  parameter int pNUM_TRIGGER_PULSES = NUM_PULSES,
  parameter int pNUM_TRIGGER_WIDTH  = NUM_WIDTH,
  parameter int pDELAY_WIDTH        = DELAY_WIDTH,
  parameter int pINDEX_WIDTH        = INDEX_WIDTH
);
  logic                                        I_arm;
  logic                                        I_trigger_enable;
  logic                                        I_match;
  logic [pNUM_TRIGGER_WIDTH-1:0]               I_num_triggers;
  logic [pNUM_TRIGGER_PULSES*pDELAY_WIDTH-1:0] I_trigger_delay;
  logic [pNUM_TRIGGER_PULSES*pDELAY_WIDTH-1:0] I_trigger_width;
  logic                                        O_trigger;
  logic                                        O_busy;
  logic                                        O_done;
  logic [pINDEX_WIDTH-1:0]                     O_pulse_index;
  logic                                        O_match_ignored;
  modport master (
    output I_arm, I_trigger_enable, I_match, I_num_triggers, I_trigger_delay, I_trigger_width,
    input  O_trigger, O_busy, O_done, O_pulse_index, O_match_ignored
  );
  modport slave (
    input  I_arm, I_trigger_enable, I_match, I_num_triggers, I_trigger_delay, I_trigger_width,
    output O_trigger, O_busy, O_done, O_pulse_index, O_match_ignored
  );
endinterface

// File: rtl/trigger_cfg_mux.sv
// trigger_cfg_mux: selects delay[idx] and width[idx] from the flat configuration arrays
module trigger_cfg_mux
  import trigger_sequencer_pkg::*;
#(
  parameter int pNUM_TRIGGER_PULSES = NUM_PULSES,
  parameter int pDELAY_WIDTH        = DELAY_WIDTH,
  parameter int pINDEX_WIDTH        = INDEX_WIDTH
) (
  input  logic [pNUM_TRIGGER_PULSES*pDELAY_WIDTH-1:0] delay_flat,
  input  logic [pNUM_TRIGGER_PULSES*pDELAY_WIDTH-1:0] width_flat,
  input  logic [pINDEX_WIDTH-1:0]                     idx,
  output logic [pDELAY_WIDTH-1:0]                     delay,
  output logic [pDELAY_WIDTH-1:0]                     width
);
  always_comb begin
    delay = delay_flat[idx*pDELAY_WIDTH +: pDELAY_WIDTH];
    width = width_flat[idx*pDELAY_WIDTH +: pDELAY_WIDTH];
  end
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: schedules up to pNUM_TRIGGER_PULSES delay/width pulses after a match
module trigger_sequencer
  import trigger_sequencer_pkg::*;
#(
  parameter int pNUM_TRIGGER_PULSES = NUM_PULSES,
  parameter int pNUM_TRIGGER_WIDTH  = NUM_WIDTH,
  parameter int pDELAY_WIDTH        = DELAY_WIDTH,
  parameter int pINDEX_WIDTH        = INDEX_WIDTH
) (
  input logic             trigger_clk,
  input logic             reset,
  trigger_sequencer_if.slave bus
);
  localparam logic [pNUM_TRIGGER_WIDTH-1:0] N_MAX = pNUM_TRIGGER_WIDTH'(pNUM_TRIGGER_PULSES);
  logic [1:0]                    state_q, state_d;
  logic [pDELAY_WIDTH-1:0]       cnt_q, cnt_d;
  logic [pINDEX_WIDTH-1:0]       index_q, index_d;
  logic [pNUM_TRIGGER_WIDTH-1:0] n_q, n_d;
  logic                          trig_q, trig_d, busy_q, busy_d, done_q, done_d, ign_q, ign_d;
  logic [pINDEX_WIDTH-1:0]       sel;
  logic [pDELAY_WIDTH-1:0]       cfg_delay, cfg_width;
  logic [pNUM_TRIGGER_WIDTH-1:0] n_in;
  logic                          last;
  // in PULSE the next load is the following pulse's delay, so look one index ahead
  always_comb begin
    n_in = bus.I_num_triggers > N_MAX ? N_MAX : bus.I_num_triggers;
    sel  = state_q == ST_PULSE ? index_q + pINDEX_WIDTH'(1) : index_q;
    last = pNUM_TRIGGER_WIDTH'(index_q) + pNUM_TRIGGER_WIDTH'(1) == n_q;
  end
  trigger_cfg_mux #(
    .pNUM_TRIGGER_PULSES(pNUM_TRIGGER_PULSES),
    .pDELAY_WIDTH       (pDELAY_WIDTH),
    .pINDEX_WIDTH       (pINDEX_WIDTH)
  ) u_cfg_mux (
    .delay_flat(bus.I_trigger_delay),
    .width_flat(bus.I_trigger_width),
    .idx       (sel),
    .delay     (cfg_delay),
    .width     (cfg_width)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    n_d     = n_q;
    trig_d  = trig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ign_d   = bus.I_match & (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      if (bus.I_match & bus.I_arm & bus.I_trigger_enable) begin
        if (n_in != '0) begin
          state_d = ST_DELAY;
          cnt_d   = cfg_delay;
          index_d = '0;
          n_d     = n_in;
          busy_d  = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (!bus.I_trigger_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      index_d = '0;
      trig_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - pDELAY_WIDTH'(1);
    end else if (state_q == ST_DELAY) begin
      trig_d  = 1'b1;
      cnt_d   = cfg_width == '0 ? '0 : cfg_width - pDELAY_WIDTH'(1);
      state_d = ST_PULSE;
    end else if (last) begin
      state_d = ST_IDLE;
      index_d = '0;
      trig_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      state_d = ST_DELAY;
      index_d = index_q + pINDEX_WIDTH'(1);
      cnt_d   = cfg_delay;
      trig_d  = 1'b0;
    end
  end
  always_ff @(posedge trigger_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      n_q     <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      n_q     <= n_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ign_q   <= ign_d;
    end
  end
  always_comb begin
    bus.O_trigger       = trig_q;
    bus.O_busy          = busy_q;
    bus.O_done          = done_q;
    bus.O_pulse_index   = index_q;
    bus.O_match_ignored = ign_q;
  end
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: directed checks of pulse timing, clamping, busy/abort/reset handling
module tb_trigger_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;
  always #5 clk = ~clk;
  trigger_sequencer_if bus ();
  trigger_sequencer dut (
    .trigger_clk(clk),
    .reset      (rst),
    .bus        (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fire();
    bus.I_match = 1'b1;
    step(1);
    bus.I_match = 1'b0;
  endtask
  task automatic set_cfg(input int i, input int d, input int w);
    logic [31:0] dv, wv;
    dv = d;
    wv = w;
    bus.I_trigger_delay[i*24 +: 24] = dv[23:0];
    bus.I_trigger_width[i*24 +: 24] = wv[23:0];
  endtask
  bit t2_trig [8] = '{1, 0, 1, 0, 1, 1, 0, 0};
  int t2_idx  [8] = '{0, 1, 1, 2, 2, 2, 0, 0};
  initial begin
    int rises, dones, highs;
    bit prev;
    bus.I_arm = 1'b1;
    bus.I_trigger_enable = 1'b1;
    bus.I_match = 1'b0;
    bus.I_num_triggers = 4'd1;
    bus.I_trigger_delay = '0;
    bus.I_trigger_width = '0;
    step(2);
    chk("rst_trig", bus.O_trigger, 0);
    chk("rst_busy", bus.O_busy, 0);
    chk("rst_done", bus.O_done, 0);
    chk("rst_ign", bus.O_match_ignored, 0);
    chk("rst_idx", bus.O_pulse_index, 0);
    rst = 1'b0;
    step(1);
    // single pulse: delay 5, width 3
    set_cfg(0, 5, 3);
    fire();
    chk("t1_busy_e0", bus.O_busy, 1);
    for (int e = 1; e <= 10; e++) begin
      step(1);
      chk($sformatf("t1_trig_e%0d", e), bus.O_trigger, (e >= 6 && e <= 8));
      chk($sformatf("t1_busy_e%0d", e), bus.O_busy, (e <= 8));
      chk($sformatf("t1_done_e%0d", e), bus.O_done, (e == 9));
    end
    // zero delays, widths 0,1,2
    bus.I_num_triggers = 4'd3;
    set_cfg(0, 0, 0);
    set_cfg(1, 0, 1);
    set_cfg(2, 0, 2);
    fire();
    for (int e = 1; e <= 8; e++) begin
      step(1);
      chk($sformatf("t2_trig_e%0d", e), bus.O_trigger, t2_trig[e-1]);
      chk($sformatf("t2_idx_e%0d", e), bus.O_pulse_index, t2_idx[e-1]);
      chk($sformatf("t2_done_e%0d", e), bus.O_done, (e == 7));
    end
    // clamp 15 -> 8 pulses
    for (int i = 0; i < 8; i++) set_cfg(i, 0, 1);
    bus.I_num_triggers = 4'd15;
    fire();
    rises = 0;
    dones = 0;
    prev = 1'b0;
    for (int e = 0; e < 40; e++) begin
      step(1);
      if (bus.O_trigger && !prev) rises++;
      if (bus.O_done) dones++;
      prev = bus.O_trigger;
    end
    chk("t3_rises", rises, 8);
    chk("t3_dones", dones, 1);
    chk("t3_busy_end", bus.O_busy, 0);
    // N = 0
    bus.I_num_triggers = 4'd0;
    fire();
    chk("t3z_done", bus.O_done, 1);
    chk("t3z_busy", bus.O_busy, 0);
    step(1);
    chk("t3z_done_gone", bus.O_done, 0);
    chk("t3z_trig", bus.O_trigger, 0);
    // match while busy, then match on the completion edge
    bus.I_num_triggers = 4'd1;
    set_cfg(0, 5, 3);
    fire();
    step(1);
    fire();
    chk("t4_ign_e2", bus.O_match_ignored, 1);
    step(1);
    chk("t4_ign_e3", bus.O_match_ignored, 0);
    step(2);
    chk("t4_trig_e5", bus.O_trigger, 0);
    step(1);
    chk("t4_trig_e6", bus.O_trigger, 1);
    step(2);
    chk("t4_trig_e8", bus.O_trigger, 1);
    fire();
    chk("t4_done_e9", bus.O_done, 1);
    chk("t4_ign_e9", bus.O_match_ignored, 1);
    chk("t4_busy_e9", bus.O_busy, 0);
    step(1);
    chk("t4_busy_e10", bus.O_busy, 0);
    chk("t4_ign_e10", bus.O_match_ignored, 0);
    // abort mid-pulse: delay 2, width 10
    set_cfg(0, 2, 10);
    fire();
    step(2);
    chk("t5_trig_e2", bus.O_trigger, 0);
    step(1);
    chk("t5_trig_e3", bus.O_trigger, 1);
    step(3);
    chk("t5_trig_e6", bus.O_trigger, 1);
    bus.I_trigger_enable = 1'b0;
    step(1);
    chk("t5_abort_trig", bus.O_trigger, 0);
    chk("t5_abort_busy", bus.O_busy, 0);
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      step(1);
      if (bus.O_done) dones++;
    end
    chk("t5_no_done", dones, 0);
    fire();
    chk("t5_disabled_busy", bus.O_busy, 0);
    chk("t5_disabled_ign", bus.O_match_ignored, 0);
    bus.I_trigger_enable = 1'b1;
    step(1);
    fire();
    chk("t5_restart_busy", bus.O_busy, 1);
    chk("t5_restart_idx", bus.O_pulse_index, 0);
    step(3);
    chk("t5_restart_trig", bus.O_trigger, 1);
    dones = 0;
    for (int e = 0; e < 20 && dones == 0; e++) begin
      step(1);
      if (bus.O_done) dones = e + 4;
    end
    chk("t5_restart_done_edge", dones, 13);
    // reset during delay of pulse 2
    bus.I_num_triggers = 4'd3;
    for (int i = 0; i < 3; i++) set_cfg(i, 3, 1);
    fire();
    step(11);
    chk("t6_idx_e11", bus.O_pulse_index, 2);
    chk("t6_busy_e11", bus.O_busy, 1);
    rst = 1'b1;
    step(1);
    chk("t6_rst_busy", bus.O_busy, 0);
    chk("t6_rst_trig", bus.O_trigger, 0);
    chk("t6_rst_idx", bus.O_pulse_index, 0);
    chk("t6_rst_done", bus.O_done, 0);
    rst = 1'b0;
    step(1);
    chk("t6_post_busy", bus.O_busy, 0);
    // arm low gating
    bus.I_arm = 1'b0;
    fire();
    chk("t6_noarm_busy", bus.O_busy, 0);
    chk("t6_noarm_ign", bus.O_match_ignored, 0);
    chk("t6_noarm_done", bus.O_done, 0);
    bus.I_arm = 1'b1;
    // maximum delay: still waiting after 1000 cycles
    bus.I_num_triggers = 4'd1;
    set_cfg(0, 24'hFFFFFF, 1);
    fire();
    highs = 0;
    for (int e = 0; e < 1000; e++) begin
      step(1);
      if (bus.O_trigger) highs++;
    end
    chk("t7_no_trig", highs, 0);
    chk("t7_busy", bus.O_busy, 1);
    bus.I_trigger_enable = 1'b0;
    step(1);
    chk("t7_abort_busy", bus.O_busy, 0);
    bus.I_trigger_enable = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
